// File: rtl/frame_fft_scheduler_if.sv
// Signal bundle between frame_fft_scheduler and its neighbours (vga, mic_sampler, fft_16point).
// The scheduler takes the slave view. The environment or bench takes the master view.
interface frame_fft_scheduler_if #(
    parameter int DATA_W = 18
);
    logic                   vblank;
    logic                   samp_start;
    logic                   samp_done;
    logic                   fft_start;
    logic                   fft_done;
    logic [16*DATA_W-1:0]   fft_re;
    logic [16*DATA_W-1:0]   bars;
    logic                   bars_valid;
    logic                   busy;
    logic                   overrun;
    logic                   timeout;
    logic                   err_clr;

    modport master (
        output vblank, samp_done, fft_done, fft_re, err_clr,
        input  samp_start, fft_start, bars, bars_valid, busy, overrun, timeout
    );

    modport slave (
        input  vblank, samp_done, fft_done, fft_re, err_clr,
        output samp_start, fft_start, bars, bars_valid, busy, overrun, timeout
    );
endinterface

// File: rtl/frame_fft_scheduler.sv
// Runs one capture -> FFT -> bar-height update sequence per vblank rising edge.
// New bars are published atomically, and hung stages and frame overruns are flagged.
module frame_fft_scheduler #(
    parameter int DATA_W      = 18,
    parameter int TIMEOUT     = 4096,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_fft_scheduler_if.slave bus
);
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] RE_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_FFT,
        S_LOAD,
        S_COMMIT
    } state_e;

    state_e              state_q, state_d;
    logic                entered_q;
    logic                vb_q;
    logic                rise;
    logic [CNT_W-1:0]    cnt_q;
    logic                cnt_last;
    logic                samp_to;
    logic                fft_to;
    logic [3:0]          idx_q;
    logic [DATA_W-1:0]   snap_q [16];
    logic [DATA_W-1:0]   work_q [16];
    logic [DATA_W-1:0]   bars_q [16];
    logic                bars_valid_q;
    logic                overrun_q;
    logic                timeout_q;
    logic [DATA_W-1:0]   re_sel;
    logic [DATA_W-1:0]   old_bar;
    logic [DATA_W-1:0]   mag;
    logic [DATA_W-1:0]   dec;
    logic [DATA_W-1:0]   load_val;
    logic [16*DATA_W-1:0] bars_flat;
    logic                samp_start;
    logic                fft_start;

    assign rise     = bus.vblank & ~vb_q;
    assign cnt_last = (cnt_q == CNT_LAST);
    // A done pulse in the final allowed cycle takes priority over the timeout.
    assign samp_to  = (state_q == S_SAMPLE) && !bus.samp_done && cnt_last;
    assign fft_to   = (state_q == S_FFT) && !bus.fft_done && cnt_last;

    // entered_q marks the first cycle after each state change; the start pulses are built from it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            entered_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            entered_q <= (state_d != state_q);
        end
    end

    // NOTE: always_comb assigns a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (rise) state_d = S_SAMPLE;
            S_SAMPLE: if (bus.samp_done) state_d = S_FFT;
                      else if (samp_to) state_d = S_IDLE;
            S_FFT:    if (bus.fft_done) state_d = S_LOAD;
                      else if (fft_to) state_d = S_IDLE;
            S_LOAD:   if (idx_q == 4'd15) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        samp_start = entered_q && (state_q == S_SAMPLE);
        fft_start  = entered_q && (state_q == S_FFT);
    end

    // Per-bin update: saturating |re| against the decayed previous height.
    always_comb begin
        re_sel  = snap_q[idx_q];
        old_bar = bars_q[idx_q];
        if (re_sel == RE_MIN)
            mag = MAG_MAX;
        else if (re_sel[DATA_W-1])
            mag = DATA_W'(0) - re_sel;
        else
            mag = re_sel;
        dec      = old_bar - (old_bar >> DECAY_SHIFT);
        load_val = (mag > dec) ? mag : dec;
    end

    // NOTE: snapshot/work/bar arrays are reset explicitly. A reset mid-frame must leave nothing stale for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vb_q         <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            bars_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                snap_q[k] <= '0;
                work_q[k] <= '0;
                bars_q[k] <= '0;
            end
        end else begin
            vb_q <= bus.vblank;

            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_SAMPLE || state_q == S_FFT)
                cnt_q <= cnt_q + CNT_W'(1);

            idx_q <= (state_q == S_LOAD) ? idx_q + 4'd1 : 4'd0;

            if (state_q == S_FFT && bus.fft_done)
                for (int k = 0; k < 16; k++)
                    snap_q[k] <= bus.fft_re[k*DATA_W +: DATA_W];

            if (state_q == S_LOAD)
                work_q[idx_q] <= load_val;

            // All sixteen bars move on one edge, so vga never sees a half-updated frame.
            if (state_q == S_COMMIT)
                for (int k = 0; k < 16; k++)
                    bars_q[k] <= work_q[k];

            bars_valid_q <= (state_q == S_COMMIT);

            if (rise && state_q != S_IDLE)
                overrun_q <= 1'b1;
            else if (bus.err_clr)
                overrun_q <= 1'b0;

            if (samp_to || fft_to)
                timeout_q <= 1'b1;
            else if (bus.err_clr)
                timeout_q <= 1'b0;
        end
    end

    always_comb begin
        bars_flat = '0;
        for (int k = 0; k < 16; k++)
            bars_flat[k*DATA_W +: DATA_W] = bars_q[k];
    end

    assign bus.samp_start = samp_start;
    assign bus.fft_start  = fft_start;
    assign bus.bars       = bars_flat;
    assign bus.bars_valid = bars_valid_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.overrun    = overrun_q;
    assign bus.timeout    = timeout_q;
endmodule
